// File: rtl/seq_generator.sv
// seq_generator: serial bit-stream transmitter.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each one out
// MSB-first on sout, one bit per clock, flagging the final bit with done.
// GAP idle cycles separate consecutive words.
// Optional feature: define SEQ_GENERATOR_PARITY_EN to append one even-parity
// bit after the data bits of every word.
module seq_generator #(
  parameter int WIDTH = 9,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The IDLE cycle that precedes the next acceptance is the last idle cycle
  // on the line, so the GAP state itself only covers the first GAP-1 of them.
  // That keeps the spacing between words at exactly GAP invalid cycles.
  localparam bit               USE_GAP_STATE = (GAP > 1);
  localparam logic [GAP_W-1:0] GAP_LOAD      = (GAP > 1) ? GAP_W'(GAP - 2) : '0;
  localparam bit               NO_GAP        = (GAP == 0);

`ifdef SEQ_GENERATOR_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SEQ_GENERATOR_PARITY_EN
    S_PARITY,
`endif
    S_GAP
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             sout_q;
  logic             sout_valid_q;
  logic             done_q;
`ifdef SEQ_GENERATOR_PARITY_EN
  logic             parity_q;
`endif

  logic accept;

  // Ready depends only on state and bit counter, never on din_valid.
  always_comb begin
    din_ready = 1'b0;
    case (state_q)
      S_IDLE:   din_ready = 1'b1;
      S_SHIFT:  din_ready = (bit_cnt_q == '0) && NO_GAP && !PARITY_EN;
`ifdef SEQ_GENERATOR_PARITY_EN
      S_PARITY: din_ready = NO_GAP;
`endif
      default:  din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid && din_ready;

  // Transmit FSM with registered serial outputs; a new word always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_GENERATOR_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes straight onto the line; the remaining bits wait in shreg_q.
      state_q      <= S_SHIFT;
      shreg_q      <= {din[WIDTH-2:0], 1'b0};
      bit_cnt_q    <= CNT_LOAD;
      sout_q       <= din[WIDTH-1];
      sout_valid_q <= 1'b1;
      done_q       <= 1'b0;
`ifdef SEQ_GENERATOR_PARITY_EN
      parity_q     <= ^din;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
        end

        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            // Present the next bit; done rides with the last data bit
            // unless a parity bit follows.
            sout_q       <= shreg_q[WIDTH-1];
            sout_valid_q <= 1'b1;
            shreg_q      <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_q    <= bit_cnt_q - CNT_ONE;
            done_q       <= (bit_cnt_q == CNT_ONE) && !PARITY_EN;
          end else begin
`ifdef SEQ_GENERATOR_PARITY_EN
            state_q      <= S_PARITY;
            sout_q       <= parity_q;
            sout_valid_q <= 1'b1;
            done_q       <= 1'b1;
`else
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (USE_GAP_STATE) begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LOAD;
            end else begin
              state_q   <= S_IDLE;
            end
`endif
          end
        end

`ifdef SEQ_GENERATOR_PARITY_EN
        S_PARITY: begin
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
          if (USE_GAP_STATE) begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_LOAD;
          end else begin
            state_q   <= S_IDLE;
          end
        end
`endif

        S_GAP: begin
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
          if (gap_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        default: begin
          state_q      <= S_IDLE;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
